// File: rtl/nv_nvdla_sdp_nrdma_ig_req_pkg.sv
// ---------------------------------------------------------------------------
// nv_nvdla_sdp_nrdma_ig_req_pkg
// Shared constants and types for the SDP NRDMA ingress request path.
//   LAT_DEPTH   : latency-FIFO entries; initial and maximum credit count
//   BURST_MAX   : max 64B entries per DMA read request (power of 2)
//   BURST_LOG2  : log2(BURST_MAX), width of the in-burst pointer offset
//   BURST_W     : width of a burst length (0..BURST_MAX)
//   REQ_SIZE_W  : width of the request size field (entries-1)
//   CREDIT_W    : width of the credit counter
//   ig_state_e  : request generator states
// ---------------------------------------------------------------------------
package nv_nvdla_sdp_nrdma_ig_req_pkg;

    localparam int LAT_DEPTH  = 160;
    localparam int BURST_MAX  = 8;
    localparam int BURST_LOG2 = $clog2(BURST_MAX);
    localparam int BURST_W    = BURST_LOG2 + 1;
    localparam int REQ_SIZE_W = 4;
    localparam int CREDIT_W   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } ig_state_e;

    // Entries left before the next BURST_MAX-aligned boundary.
    function automatic logic [BURST_W-1:0] burst_room(input logic [BURST_LOG2-1:0] ptr_low);
        return BURST_W'(BURST_MAX) - BURST_W'(ptr_low);
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_nrdma_credit_cnt.sv
// ---------------------------------------------------------------------------
// nv_nvdla_sdp_nrdma_credit_cnt
// Latency-FIFO credit counter. Starts full (LAT_DEPTH), decrements by the
// burst length when a request is accepted, increments by one per egress pop.
// A pop arriving while already full (and no accept in the same cycle) is
// dropped and flags credit_err, which stays set until reset.
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, async active-high reset
//   take_en, take_num               : request accepted, entries reserved
//   give                            : one entry popped by egress
//   credit_cnt                      : current free credits (registered)
//   credit_next                     : credits after this cycle's updates
//   credit_err                      : sticky over-return flag
// ---------------------------------------------------------------------------
module nv_nvdla_sdp_nrdma_credit_cnt
    import nv_nvdla_sdp_nrdma_ig_req_pkg::*;
(
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rst,
    input  logic                take_en,
    input  logic [BURST_W-1:0]  take_num,
    input  logic                give,
    output logic [CREDIT_W-1:0] credit_cnt,
    output logic [CREDIT_W-1:0] credit_next,
    output logic                credit_err
);

    localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(LAT_DEPTH);

    logic [CREDIT_W-1:0] credit_reg;
    logic                err_reg;
    logic                err_next;

    always_comb begin
        credit_next = credit_reg;
        err_next    = err_reg;
        if (give && !take_en && (credit_reg == CREDIT_FULL)) begin
            err_next = 1'b1;
        end else begin
            // An accept never exceeds the available credit, so no underflow.
            credit_next = credit_reg
                        - (take_en ? CREDIT_W'(take_num) : '0)
                        + CREDIT_W'(give);
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            credit_reg <= CREDIT_FULL;
            err_reg    <= 1'b0;
        end else begin
            credit_reg <= credit_next;
            err_reg    <= err_next;
        end
    end

    assign credit_cnt = credit_reg;
    assign credit_err = err_reg;

endmodule

// File: rtl/nv_nvdla_sdp_nrdma_ig_req.sv
// ---------------------------------------------------------------------------
// nv_nvdla_sdp_nrdma_ig_req
// Ingress read-request generator for the SDP NRDMA path. Splits one surface
// read (cfg_size+1 entries of 64B starting at cfg_base_addr) into DMA read
// requests of up to BURST_MAX entries that never cross a BURST_MAX-aligned
// boundary. A request is only presented once the latency FIFO has credit for
// all of its entries, so every returning read has a slot.
// Ports:
//   nvdla_core_clk / nvdla_core_rst        : clock, async active-high reset
//   op_load, cfg_base_addr, cfg_size       : start pulse and surface config
//   dma_rd_req_valid/ready/addr/size       : DMA read request channel
//   lat_rd_pop                             : egress returned one credit
//   busy, op_done                          : operation status
//   credit_cnt, credit_err                 : free credits, sticky over-return
// ---------------------------------------------------------------------------
module nv_nvdla_sdp_nrdma_ig_req
    import nv_nvdla_sdp_nrdma_ig_req_pkg::*;
#(
    parameter int AW    = 64,
    parameter int CNT_W = 14
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic                  op_load,
    input  logic [AW-1:0]         cfg_base_addr,
    input  logic [CNT_W-1:0]      cfg_size,
    output logic                  dma_rd_req_valid,
    input  logic                  dma_rd_req_ready,
    output logic [AW-1:0]         dma_rd_req_addr,
    output logic [REQ_SIZE_W-1:0] dma_rd_req_size,
    input  logic                  lat_rd_pop,
    output logic                  busy,
    output logic                  op_done,
    output logic [CREDIT_W-1:0]   credit_cnt,
    output logic                  credit_err
);

    localparam int PW = AW - 6;     // entry pointer width
    localparam int RW = CNT_W + 1;  // remaining-entry counter width

    // Byte offset within an entry is meaningless for 64B-aligned requests.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cfg_base_addr[5:0];

    ig_state_e              state_reg, state_next;
    logic [PW-1:0]          ptr_reg, ptr_next;
    logic [RW-1:0]          remain_reg, remain_next;
    logic                   valid_reg, valid_next;
    logic [AW-1:0]          addr_reg, addr_next;
    logic [REQ_SIZE_W-1:0]  size_reg, size_next;
    logic                   busy_reg, busy_next;
    logic                   op_done_reg, op_done_next;

    logic [BURST_W-1:0]     burst_cur;
    logic [BURST_W-1:0]     burst_next;
    logic                   accept;
    logic                   last_accept;
    logic [CREDIT_W-1:0]    credit_next;

    function automatic logic [BURST_W-1:0] calc_burst(
        input logic [BURST_LOG2-1:0] ptr_low,
        input logic [RW-1:0]         remain
    );
        logic [BURST_W-1:0] room;
        room = burst_room(ptr_low);
        if (remain < RW'(room)) begin
            return remain[BURST_W-1:0];
        end
        return room;
    endfunction

    // Burst of the request currently held (or about to be presented).
    assign burst_cur   = calc_burst(ptr_reg[BURST_LOG2-1:0], remain_reg);
    assign accept      = valid_reg && dma_rd_req_ready;
    assign last_accept = accept && (RW'(burst_cur) == remain_reg);

    nv_nvdla_sdp_nrdma_credit_cnt u_credit (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .take_en        (accept),
        .take_num       (burst_cur),
        .give           (lat_rd_pop),
        .credit_cnt     (credit_cnt),
        .credit_next    (credit_next),
        .credit_err     (credit_err)
    );

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        remain_next  = remain_reg;
        busy_next    = busy_reg;
        op_done_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (op_load) begin
                    state_next  = REQ;
                    ptr_next    = cfg_base_addr[AW-1:6];
                    remain_next = {1'b0, cfg_size} + RW'(1);
                    busy_next   = 1'b1;
                end
            end
            REQ: begin
                if (accept) begin
                    ptr_next    = ptr_reg + PW'(burst_cur);
                    remain_next = remain_reg - RW'(burst_cur);
                    if (last_accept) begin
                        state_next   = IDLE;
                        busy_next    = 1'b0;
                        op_done_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Valid is decided one cycle ahead against next-cycle credit, so a
        // new request can follow an accepted one with no bubble. While a
        // request waits, ptr is frozen and credit cannot shrink, so the
        // request stays valid with the same address and size.
        burst_next = calc_burst(ptr_next[BURST_LOG2-1:0], remain_next);
        valid_next = (state_next == REQ) && (credit_next >= CREDIT_W'(burst_next));
        addr_next  = addr_reg;
        size_next  = size_reg;
        if (valid_next) begin
            addr_next = {ptr_next, 6'b0};
            size_next = REQ_SIZE_W'(burst_next - BURST_W'(1));
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            remain_reg  <= '0;
            valid_reg   <= 1'b0;
            addr_reg    <= '0;
            size_reg    <= '0;
            busy_reg    <= 1'b0;
            op_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            remain_reg  <= remain_next;
            valid_reg   <= valid_next;
            addr_reg    <= addr_next;
            size_reg    <= size_next;
            busy_reg    <= busy_next;
            op_done_reg <= op_done_next;
        end
    end

    assign dma_rd_req_valid = valid_reg;
    assign dma_rd_req_addr  = addr_reg;
    assign dma_rd_req_size  = size_reg;
    assign busy             = busy_reg;
    assign op_done          = op_done_reg;

endmodule

// File: tb/tb_nv_nvdla_sdp_nrdma_ig_req.sv
module tb_nv_nvdla_sdp_nrdma_ig_req;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_load = 1'b0;
    logic [63:0] base = '0;
    logic [13:0] size = '0;
    logic        ready = 1'b0;
    logic        pop = 1'b0;
    logic        valid;
    logic [63:0] addr;
    logic [3:0]  rsize;
    logic        busy;
    logic        op_done;
    logic [7:0]  credit;
    logic        err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  size;
    } req_t;

    req_t exp_q[$];     // bursts still expected from the current operation
    req_t acc_log[$];   // requests actually accepted from the DUT
    int   m_credit = 160;
    bit   m_err = 1'b0;
    bit   m_done = 1'b0;

    always #5 clk = ~clk;

    nv_nvdla_sdp_nrdma_ig_req dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rst   (rst),
        .op_load          (op_load),
        .cfg_base_addr    (base),
        .cfg_size         (size),
        .dma_rd_req_valid (valid),
        .dma_rd_req_ready (ready),
        .dma_rd_req_addr  (addr),
        .dma_rd_req_size  (rsize),
        .lat_rd_pop       (pop),
        .busy             (busy),
        .op_done          (op_done),
        .credit_cnt       (credit),
        .credit_err       (err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference split: walk the entry range, cutting at aligned boundaries.
    task automatic push_op(input logic [63:0] b, input logic [13:0] s);
        logic [57:0] p;
        int rem;
        int room;
        int blen;
        req_t r;
        p   = b[63:6];
        rem = int'(s) + 1;
        while (rem > 0) begin
            room = 8 - int'(p[2:0]);
            blen = (rem < room) ? rem : room;
            r.addr = {p, 6'b0};
            r.size = 4'(blen - 1);
            exp_q.push_back(r);
            p   = p + 58'(blen);
            rem = rem - blen;
        end
    endtask

    // Monitor / scoreboard: compare at the falling edge, then advance the
    // model by what the coming rising edge will do.
    always @(negedge clk) begin
        bit act;
        bit ev;
        bit acc;
        req_t r;
        if (rst) begin
            chk("rst_valid", valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", op_done, 0);
            chk("rst_credit", credit, 160);
            chk("rst_err", err, 0);
            chk("rst_addr", addr, 0);
            chk("rst_size", rsize, 0);
            exp_q.delete();
            m_credit = 160;
            m_err    = 1'b0;
            m_done   = 1'b0;
        end else begin
            act = (exp_q.size() != 0);
            ev  = act && (m_credit >= int'(exp_q[0].size) + 1);
            chk("valid", valid, 64'(ev));
            chk("busy", busy, 64'(act));
            chk("op_done", op_done, 64'(m_done));
            chk("credit", credit, 64'(m_credit));
            chk("credit_err", err, 64'(m_err));
            if (ev) begin
                chk("req_addr", addr, exp_q[0].addr);
                chk("req_size", rsize, 64'(exp_q[0].size));
            end
            if (valid && ready) begin
                r.addr = addr;
                r.size = rsize;
                acc_log.push_back(r);
                $display("req accepted addr=%0h size=%0d credit=%0d", addr, rsize, credit);
            end
            m_done = 1'b0;
            acc = ev && ready;
            if (acc) begin
                m_credit = m_credit - (int'(exp_q[0].size) + 1);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_done = 1'b1;
            end
            if (pop) begin
                if (m_credit == 160 && !acc) m_err = 1'b1;
                else m_credit = m_credit + 1;
            end
            if (op_load && !act) push_op(base, size);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_dut();
        rst = 1'b1;
        op_load = 1'b0;
        pop = 1'b0;
        cyc(); cyc(); cyc();
        rst = 1'b0;
        cyc();
        acc_log.delete();
    endtask

    task automatic start_op(input logic [63:0] b, input logic [13:0] s);
        base = b;
        size = s;
        op_load = 1'b1;
        cyc();
        op_load = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s timeout pending=%0d want=0", nm, exp_q.size());
        end
        cyc(); cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_dut();

        // 1: 13 entries from 0x1000
        ready = 1'b1;
        start_op(64'h1000, 14'd12);
        wait_idle("t1_done", 100);
        chk("t1_nreq", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            chk("t1_a0", acc_log[0].addr, 64'h1000);
            chk("t1_s0", acc_log[0].size, 7);
            chk("t1_a1", acc_log[1].addr, 64'h1200);
            chk("t1_s1", acc_log[1].size, 4);
        end
        chk("t1_credit", credit, 147);

        // 2: unaligned start 0x1140, 10 entries
        rst_dut();
        ready = 1'b1;
        start_op(64'h1140, 14'd9);
        wait_idle("t2_done", 100);
        chk("t2_nreq", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            chk("t2_a0", acc_log[0].addr, 64'h1140);
            chk("t2_s0", acc_log[0].size, 2);
            chk("t2_a1", acc_log[1].addr, 64'h1200);
            chk("t2_s1", acc_log[1].size, 6);
        end
        chk("t2_credit", credit, 150);

        // 3: 200 entries exhaust credit, then pops unlock the next burst
        rst_dut();
        ready = 1'b1;
        start_op(64'h0, 14'd199);
        begin
            int n;
            n = 0;
            while (acc_log.size() < 20 && n < 200) begin cyc(); n++; end
        end
        ready = 1'b0;
        cyc(); cyc(); cyc();
        chk("t3_nreq", acc_log.size(), 20);
        chk("t3_credit0", credit, 0);
        chk("t3_stall", valid, 0);
        pop = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        chk("t3_credit7", credit, 7);
        chk("t3_still_stall", valid, 0);
        cyc();
        pop = 1'b0;
        chk("t3_valid8", valid, 1);
        chk("t3_addr8", addr, 64'h2800);
        chk("t3_size8", rsize, 7);

        // 4: request held under back-pressure, then accept + pop together
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_hold_valid", valid, 1);
            chk("t4_hold_addr", addr, 64'h2800);
            chk("t4_hold_size", rsize, 7);
        end
        ready = 1'b1;
        pop = 1'b1;
        cyc();
        ready = 1'b0;
        pop = 1'b0;
        chk("t4_credit", credit, 1);
        chk("t4_last_addr", acc_log[$].addr, 64'h2800);
        cyc();
        chk("t4_restall", valid, 0);

        // 5: over-return while idle and full
        rst_dut();
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        chk("t5_credit", credit, 160);
        chk("t5_err", err, 1);
        cyc(); cyc(); cyc();
        chk("t5_err_sticky", err, 1);
        rst_dut();
        chk("t5_err_cleared", err, 0);

        // 6: async reset mid-operation, then a clean restart
        ready = 1'b0;
        start_op(64'h3000, 14'd20);
        cyc();
        chk("t6_valid_before", valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_valid_rst", valid, 0);
        chk("t6_busy_rst", busy, 0);
        chk("t6_credit_rst", credit, 160);
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        acc_log.delete();
        ready = 1'b1;
        start_op(64'h40, 14'd3);
        wait_idle("t6_done", 100);
        chk("t6_nreq", acc_log.size(), 1);
        if (acc_log.size() == 1) begin
            chk("t6_a0", acc_log[0].addr, 64'h40);
            chk("t6_s0", acc_log[0].size, 3);
        end
        chk("t6_credit", credit, 156);

        // Random operations with random back-pressure and credit returns
        rst_dut();
        for (int k = 0; k < 12; k++) begin
            logic [63:0] b;
            int s;
            int n;
            b = {$urandom(), $urandom()};
            if (k == 0) b = 64'hFFFF_FFFF_FFFF_FF40;
            s = (k % 3 == 0) ? int'($urandom_range(150, 300)) : int'($urandom_range(0, 40));
            ready = ($urandom_range(0, 1) == 1);
            start_op(b, 14'(s));
            n = 0;
            while (exp_q.size() != 0 && n < 4000) begin
                ready   = ($urandom_range(0, 3) != 0);
                pop     = (m_credit < 160) && ($urandom_range(0, 1) == 1);
                op_load = (exp_q.size() > 1) && ($urandom_range(0, 15) == 0);
                if (op_load) begin
                    base = {$urandom(), $urandom()};
                    size = 14'($urandom_range(0, 50));
                end
                cyc();
                n++;
            end
            op_load = 1'b0;
            pop = 1'b0;
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL rnd_timeout op=%0d pending=%0d want=0", k, exp_q.size());
            end
            n = 0;
            while (m_credit < 160 && n < 400) begin
                pop = 1'b1;
                cyc();
                n++;
            end
            pop = 1'b0;
            cyc(); cyc();
            chk("rnd_drained_credit", credit, 160);
            chk("rnd_idle", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
